// File: rtl/rv32_types.sv
// Shared RV32 pipeline types: scoreboard slot layout, bypass-select encoding
// and result-latency constants.
package rv32_types;

    // Slot countdown width; must cover the widest id_lat of any instance.
    localparam int unsigned SB_CNT_W = 4;

    localparam int unsigned SEL_RF    = 0;
    localparam int unsigned SEL_SLOT0 = 1;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 2;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [SB_CNT_W-1:0] cnt;
    } sb_slot_t;

    function automatic logic sb_live(input sb_slot_t s);
        return s.valid && (s.rd != 5'd0);
    endfunction

endpackage

// File: rtl/rv32_sb_slot_match.sv
// Priority finder for one source register over the scoreboard slots:
// reports the youngest live writer, whether its result is ready, and its index.
module rv32_sb_slot_match
    import rv32_types::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic             en_i,
    input  logic [4:0]       rs_i,
    input  sb_slot_t         slots_i [DEPTH],
    output logic             hit_o,
    output logic             ready_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan oldest to youngest so the lowest matching index is the last to win.
    always_comb begin
        hit_o   = 1'b0;
        ready_o = 1'b0;
        idx_o   = '0;
        if (en_i && (rs_i != 5'd0)) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (sb_live(slots_i[DEPTH-1-j]) && (slots_i[DEPTH-1-j].rd == rs_i)) begin
                    hit_o   = 1'b1;
                    ready_o = (slots_i[DEPTH-1-j].cnt == '0);
                    idx_o   = IDX_W'(DEPTH - 1 - j);
                end
            end
        end
    end

endmodule

// File: rtl/rv32_scoreboard_hazard_unit.sv
// Decode-stage hazard unit: shift register of in-flight writers with latency
// countdowns, per-source bypass selection, stall generation and stall counter.
module rv32_scoreboard_hazard_unit
    import rv32_types::*;
#(
    parameter  int unsigned NUM_RS  = 2,
    parameter  int unsigned DEPTH   = 3,
    parameter  int unsigned MAX_LAT = 2,
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1),
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid_i,
    input  logic [NUM_RS-1:0]       id_use_rs_i,
    input  logic [NUM_RS*5-1:0]     id_rs_i,
    input  logic [4:0]              id_rd_i,
    input  logic                    id_wb_i,
    input  logic [LAT_W-1:0]        id_lat_i,
    input  logic                    pipe_advance_i,
    input  logic [DEPTH-1:0]        flush_mask_i,
    output logic                    stall_o,
    output logic                    issue_o,
    output logic [NUM_RS*SEL_W-1:0] bypass_sel_o,
    output logic [31:0]             stall_cycles_o
);

    sb_slot_t          slot_q [DEPTH];
    sb_slot_t          slot_d [DEPTH];
    sb_slot_t          slot_f [DEPTH];
    logic [31:0]       stall_cycles_q;
    logic [31:0]       stall_cycles_d;
    logic [NUM_RS-1:0] hit;
    logic [NUM_RS-1:0] rdy;
    logic [SEL_W-1:0]  idx [NUM_RS];

    for (genvar i = 0; i < NUM_RS; i++) begin : g_src
        rv32_sb_slot_match #(
            .DEPTH (DEPTH),
            .IDX_W (SEL_W)
        ) u_match (
            .en_i    (id_valid_i & id_use_rs_i[i]),
            .rs_i    (id_rs_i[i*5 +: 5]),
            .slots_i (slot_q),
            .hit_o   (hit[i]),
            .ready_o (rdy[i]),
            .idx_o   (idx[i])
        );
    end

    always_comb begin
        bypass_sel_o = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (hit[i] && rdy[i]) begin
                bypass_sel_o[i*SEL_W +: SEL_W] = idx[i] + SEL_W'(SEL_SLOT0);
            end
        end
        stall_o = id_valid_i & (|(hit & ~rdy));
        issue_o = id_valid_i & ~stall_o & pipe_advance_i;
    end

    // Flush masks the current contents first, so a squashed entry shifts on as a bubble.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot_f[k]       = slot_q[k];
            slot_f[k].valid = slot_q[k].valid & ~flush_mask_i[k];
        end
        slot_d = slot_f;
        if (pipe_advance_i) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_f[k-1];
                if (slot_f[k-1].cnt != '0) begin
                    slot_d[k].cnt = slot_f[k-1].cnt - SB_CNT_W'(1);
                end
            end
            slot_d[0].valid = issue_o & id_wb_i & (id_rd_i != 5'd0);
            slot_d[0].rd    = id_rd_i;
            slot_d[0].cnt   = SB_CNT_W'(id_lat_i);
        end
        stall_cycles_d = stall_cycles_q + (stall_o ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            slot_q         <= slot_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

    a_lat_legal: assert property (@(posedge clk) disable iff (rst)
        (id_valid_i && id_wb_i) |-> (32'(id_lat_i) <= DEPTH - 1));

endmodule

// File: tb/tb_rv32_scoreboard_hazard_unit.sv
// Directed bench for the scoreboard hazard unit (NUM_RS=2, DEPTH=3, MAX_LAT=2).
module tb_rv32_scoreboard_hazard_unit;
    import rv32_types::*;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_use_rs;
    logic [9:0]  id_rs;
    logic [4:0]  id_rd;
    logic        id_wb;
    logic [1:0]  id_lat;
    logic        pipe_advance;
    logic [2:0]  flush_mask;
    logic        stall;
    logic        issue;
    logic [3:0]  bypass_sel;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    rv32_scoreboard_hazard_unit #(
        .NUM_RS  (2),
        .DEPTH   (3),
        .MAX_LAT (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid),
        .id_use_rs_i    (id_use_rs),
        .id_rs_i        (id_rs),
        .id_rd_i        (id_rd),
        .id_wb_i        (id_wb),
        .id_lat_i       (id_lat),
        .pipe_advance_i (pipe_advance),
        .flush_mask_i   (flush_mask),
        .stall_o        (stall),
        .issue_o        (issue),
        .bypass_sel_o   (bypass_sel),
        .stall_cycles_o (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] use_rs, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic wb,
                       input int unsigned lat, input logic adv, input logic [2:0] fl);
        id_valid     = v;
        id_use_rs    = use_rs;
        id_rs        = {r2, r1};
        id_rd        = rd;
        id_wb        = wb;
        id_lat       = 2'(lat);
        pipe_advance = adv;
        flush_mask   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic st, input logic is, input logic [3:0] sel);
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        chk({tag, "_issue"}, 32'(issue), 32'(is));
        chk({tag, "_sel"}, 32'(bypass_sel), 32'(sel));
    endtask

    task automatic drain();
        repeat (3) begin
            tick();
            drv(0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        outs("reset", 0, 0, 4'd0);
        chk("reset_sc", stall_cycles, 32'd0);

        // load x5, then dependent reader: one stall, then bypass from slot 1
        tick(); drv(1, 2'b00, 0, 0, 5, 1, LAT_LOAD, 1, 3'b000);
        outs("ld_issue", 0, 1, 4'd0);
        tick(); drv(1, 2'b01, 5, 0, 6, 1, LAT_ALU, 1, 3'b000);
        outs("ld_use", 1, 0, 4'd0);
        tick();
        outs("ld_use2", 0, 1, 4'd2);
        chk("ld_sc", stall_cycles, 32'd1);
        drain();

        // ALU x3 then readers: slot 0, slot 1, slot 2, then retired
        tick(); drv(1, 2'b00, 0, 0, 3, 1, LAT_ALU, 1, 3'b000);
        outs("alu_wr", 0, 1, 4'd0);
        tick(); drv(1, 2'b11, 3, 3, 8, 1, LAT_ALU, 1, 3'b000);
        outs("alu_s0", 0, 1, 4'b0101);
        tick(); drv(1, 2'b01, 3, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("alu_s1", 0, 1, 4'd2);
        tick();
        outs("alu_s2", 0, 1, 4'd3);
        tick();
        outs("alu_ret", 0, 1, 4'd0);
        drain();

        // mul x7 with three frozen cycles before two advancing stalls
        tick(); drv(1, 2'b00, 0, 0, 7, 1, LAT_MUL, 1, 3'b000);
        outs("mul_wr", 0, 1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); drv(1, 2'b01, 7, 0, 0, 0, LAT_ALU, 0, 3'b000);
            outs("mul_frz", 1, 0, 4'd0);
        end
        tick(); drv(1, 2'b01, 7, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("mul_adv1", 1, 0, 4'd0);
        tick();
        outs("mul_adv2", 1, 0, 4'd0);
        tick();
        outs("mul_go", 0, 1, 4'd3);
        chk("mul_sc", stall_cycles, 32'd6);
        drain();

        // writes to x0 never create hazards
        tick(); drv(1, 2'b00, 0, 0, 0, 1, LAT_MUL, 1, 3'b000);
        outs("x0_wr", 0, 1, 4'd0);
        tick(); drv(1, 2'b11, 0, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("x0_rd", 0, 1, 4'd0);
        drain();

        // flush of slot 0 removes the pending load
        tick(); drv(1, 2'b00, 0, 0, 9, 1, LAT_LOAD, 1, 3'b000);
        outs("fl_wr", 0, 1, 4'd0);
        tick(); drv(1, 2'b01, 9, 0, 0, 0, LAT_ALU, 1, 3'b001);
        outs("fl_stall", 1, 0, 4'd0);
        tick(); drv(1, 2'b01, 9, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("fl_after", 0, 1, 4'd0);
        chk("fl_sc", stall_cycles, 32'd7);
        drain();

        // two writers of x4: younger (load) wins and stalls
        tick(); drv(1, 2'b00, 0, 0, 4, 1, LAT_ALU, 1, 3'b000);
        tick(); drv(1, 2'b00, 0, 0, 4, 1, LAT_LOAD, 1, 3'b000);
        outs("dup_wr", 0, 1, 4'd0);
        tick(); drv(1, 2'b01, 4, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("dup_stall", 1, 0, 4'd0);
        tick();
        outs("dup_go", 0, 1, 4'd2);
        chk("dup_sc", stall_cycles, 32'd8);
        drain();

        // reset during a stall clears the scoreboard at once
        tick(); drv(1, 2'b00, 0, 0, 10, 1, LAT_MUL, 1, 3'b000);
        tick(); drv(1, 2'b01, 10, 0, 0, 0, LAT_ALU, 0, 3'b000);
        outs("rs_stall", 1, 0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_clr_stall", 32'(stall), 32'd0);
        chk("rs_clr_sc", stall_cycles, 32'd0);
        tick();
        rst = 1'b0;
        drv(1, 2'b01, 10, 0, 0, 0, LAT_ALU, 1, 3'b000);
        outs("rs_release", 0, 1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
